// File: rtl/nn_pkg.sv
// Shared defaults and FSM state type for the perceptron layer sequencer.
package nn_pkg;

    localparam int unsigned NUM_INPUTS_DEF  = 784;
    localparam int unsigned NUM_NEURONS_DEF = 10;
    localparam int unsigned SUM_WIDTH_DEF   = 11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        ARGMAX,
        DONE
    } state_e;

endpackage

// File: rtl/layer_sequencer_argmax_seq.sv
// Sequential argmax: scans one neuron sum per step, keeps the running
// maximum and its index; ties keep the lowest index.
module argmax_seq
    import nn_pkg::*;
#(
    parameter  int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
    parameter  int unsigned SUM_WIDTH   = SUM_WIDTH_DEF,
    localparam int unsigned IW          = $clog2(NUM_NEURONS)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic                             step_i,
    input  logic [NUM_NEURONS*SUM_WIDTH-1:0] sums_i,
    output logic                             last_o,
    output logic [IW-1:0]                    best_next_o
);

    logic        [IW-1:0]        idx_q, idx_d;
    logic        [IW-1:0]        best_q, best_d;
    logic signed [SUM_WIDTH-1:0] max_q, max_d;
    logic signed [SUM_WIDTH-1:0] sum_arr [NUM_NEURONS];
    logic signed [SUM_WIDTH-1:0] cand;
    logic                        take;

    // Unpack the flattened sum bus into a signed per-neuron array.
    always_comb begin
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            sum_arr[i] = sums_i[i*SUM_WIDTH +: SUM_WIDTH];
        end
    end

    assign cand   = sum_arr[idx_q];
    // First neuron always seeds the maximum; later ones must be strictly greater.
    assign take   = (idx_q == '0) || (cand > max_q);
    assign last_o = (idx_q == IW'(NUM_NEURONS - 1));

    // Next-state for index, running max and best index.
    always_comb begin
        idx_d  = idx_q;
        max_d  = max_q;
        best_d = best_q;
        if (start_i) begin
            idx_d  = '0;
            max_d  = '0;
            best_d = '0;
        end else if (step_i) begin
            if (take) begin
                max_d  = cand;
                best_d = idx_q;
            end
            if (!last_o) begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Result including the current step, so the caller can latch it on the last step.
    assign best_next_o = best_d;

    // Scan registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            max_q  <= '0;
            best_q <= '0;
        end else begin
            idx_q  <= idx_d;
            max_q  <= max_d;
            best_q <= best_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Perceptron layer sequencer: clears the accumulators, streams NUM_INPUTS
// addresses to the input/weight memories (stallable by hold), then picks
// the neuron with the largest signed sum.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter  int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
    parameter  int unsigned SUM_WIDTH   = SUM_WIDTH_DEF,
    localparam int unsigned AW          = $clog2(NUM_INPUTS),
    localparam int unsigned CW          = $clog2(NUM_NEURONS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             hold,
    input  logic [NUM_NEURONS*SUM_WIDTH-1:0] sums,
    output logic [AW-1:0]                    addr,
    output logic                             rd_en,
    output logic                             clear,
    output logic                             en,
    output logic                             busy,
    output logic                             done,
    output logic [CW-1:0]                    class_out,
    output logic                             class_valid
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            en_q;
    logic [CW-1:0]   class_out_q, class_out_d;
    logic            class_valid_q, class_valid_d;
    logic            am_start, am_step, am_last;
    logic [CW-1:0]   am_best;

    argmax_seq #(
        .NUM_NEURONS (NUM_NEURONS),
        .SUM_WIDTH   (SUM_WIDTH)
    ) u_argmax (
        .clk_i       (clk),
        .rst_ni      (rst),
        .start_i     (am_start),
        .step_i      (am_step),
        .sums_i      (sums),
        .last_o      (am_last),
        .best_next_o (am_best)
    );

    // Next-state, address and strobe generation.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_en         = 1'b0;
        class_out_d   = class_out_q;
        class_valid_d = class_valid_q;
        am_start      = 1'b0;
        am_step       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = CLEAR;
                    addr_d        = '0;
                    class_valid_d = 1'b0;
                end
            end
            CLEAR: begin
                addr_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    // Address parks on the last entry rather than wrapping.
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                am_start = 1'b1;
                state_d  = ARGMAX;
            end
            ARGMAX: begin
                am_step = 1'b1;
                // Latch on the last step so the result is visible alongside done.
                if (am_last) begin
                    class_out_d   = am_best;
                    class_valid_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; en is rd_en delayed to match memory read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            en_q          <= 1'b0;
            class_out_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            en_q          <= rd_en;
            class_out_q   <= class_out_d;
            class_valid_q <= class_valid_d;
        end
    end

    assign addr        = addr_q;
    assign en          = en_q;
    assign clear       = (state_q == CLEAR);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign class_out   = class_out_q;
    assign class_valid = class_valid_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with NUM_INPUTS=4, NUM_NEURONS=3, SUM_WIDTH=11.
// Cycle 0 is the cycle in which start is first presented.
module tb_layer_sequencer;

    localparam int unsigned NI = 4;
    localparam int unsigned NN = 3;
    localparam int unsigned SW = 11;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             hold  = 1'b0;
    logic [NN*SW-1:0] sums  = '0;
    logic [1:0]       addr;
    logic             rd_en, clear, en, busy, done;
    logic [1:0]       class_out;
    logic             class_valid;

    int checks   = 0;
    int failures = 0;

    int          done_cyc, last_done, done_cnt, en_cnt, clear_cnt, clear_cyc;
    logic [1:0]  co_done;
    logic        cv_done;
    logic [1:0]  addr_tr [24];
    logic [23:0] rd_v, en_v, cv_v, busy_v;

    layer_sequencer #(
        .NUM_INPUTS  (NI),
        .NUM_NEURONS (NN),
        .SUM_WIDTH   (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold        (hold),
        .sums        (sums),
        .addr        (addr),
        .rd_en       (rd_en),
        .clear       (clear),
        .en          (en),
        .busy        (busy),
        .done        (done),
        .class_out   (class_out),
        .class_valid (class_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NN*SW-1:0] pack3(input int s0, input int s1, input int s2);
        logic [SW-1:0] a, b, c;
        a = SW'(s0);
        b = SW'(s1);
        c = SW'(s2);
        return {c, b, a};
    endfunction

    // Drive 24 cycles: start from the pulse mask, hold inside [hlo,hhi]; record outputs.
    task automatic infer(input logic [NN*SW-1:0] s, input logic [23:0] pulses,
                         input int hlo, input int hhi);
        done_cyc  = -1;
        last_done = -1;
        done_cnt  = 0;
        en_cnt    = 0;
        clear_cnt = 0;
        clear_cyc = -1;
        co_done   = '0;
        cv_done   = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            sums  = s;
            start = pulses[c];
            hold  = (c >= hlo) && (c <= hhi);
            #1;
            addr_tr[c] = addr;
            rd_v[c]    = rd_en;
            en_v[c]    = en;
            cv_v[c]    = class_valid;
            busy_v[c]  = busy;
            if (en) en_cnt++;
            if (clear) begin
                clear_cnt++;
                clear_cyc = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                last_done = c;
                co_done   = class_out;
                cv_done   = class_valid;
            end
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {addr, rd_en, clear, en, busy, done, class_out, class_valid}, 0);
        rst = 1'b1;

        // Basic inference, sums {5,-3,9}
        infer(pack3(5, -3, 9), 24'h000001, -1, -1);
        chk("s1_clear_cycle", clear_cyc, 1);
        chk("s1_clear_count", clear_cnt, 1);
        chk("s1_addr_seq", {addr_tr[2], addr_tr[3], addr_tr[4], addr_tr[5]}, 8'b00_01_10_11);
        chk("s1_rd_en_pattern", rd_v[6:1], 6'b011110);
        chk("s1_en_pattern", en_v[7:2], 6'b011110);
        chk("s1_en_count", en_cnt, 4);
        chk("s1_done_cycle", done_cyc, 10);
        chk("s1_done_count", done_cnt, 1);
        chk("s1_class", co_done, 2);
        chk("s1_valid_at_done", cv_done, 1);
        chk("s1_busy_span", busy_v[10:1], 10'h3FF);
        chk("s1_idle_after", busy_v[11], 0);

        // Hold during cycles 3-4
        infer(pack3(5, -3, 9), 24'h000001, 3, 4);
        chk("s2_addr_seq", {addr_tr[2], addr_tr[3], addr_tr[4], addr_tr[5], addr_tr[6], addr_tr[7]},
            12'b00_01_01_01_10_11);
        chk("s2_rd_en_pattern", rd_v[8:2], 7'b0111001);
        chk("s2_en_pattern", en_v[9:2], 8'b01110010);
        chk("s2_en_count", en_cnt, 4);
        chk("s2_done_cycle", done_cyc, 12);
        chk("s2_class", co_done, 2);

        // Tie resolves to lowest index; class_valid drops on start
        infer(pack3(7, 7, -1), 24'h000001, -1, -1);
        chk("s3_valid_before", cv_v[0], 1);
        chk("s3_valid_dropped", cv_v[1], 0);
        chk("s3_addr_in_clear", addr_tr[1], 0);
        chk("s3_done_cycle", done_cyc, 10);
        chk("s3_class_tie", co_done, 0);

        // All-negative sums need a signed compare
        infer(pack3(-8, -2, -5), 24'h000001, -1, -1);
        chk("s4_class_signed", co_done, 1);
        chk("s4_done_cycle", done_cyc, 10);

        // Start in RUN (3) and DONE (10) ignored; start at 11 accepted
        infer(pack3(5, -3, 9), 24'h000C09, -1, -1);
        chk("s5_done_count", done_cnt, 2);
        chk("s5_first_done", done_cyc, 10);
        chk("s5_second_done", last_done, 21);
        chk("s5_clear_count", clear_cnt, 2);
        chk("s5_en_count", en_cnt, 8);
        chk("s5_class", co_done, 2);

        // Asynchronous reset mid-inference (cycle 4)
        @(negedge clk);
        sums  = pack3(5, -3, 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_outputs_zero", {addr, rd_en, clear, en, busy, done, class_out, class_valid}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle", busy, 0);
        infer(pack3(-8, -2, -5), 24'h000001, -1, -1);
        chk("rst_after_done_cycle", done_cyc, 10);
        chk("rst_after_class", co_done, 1);

        // class_out held while idle
        repeat (3) @(negedge clk);
        #1;
        chk("class_held", class_out, 1);
        chk("valid_held", class_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 784: products accumulated per inference.
REQ-002 SHALL have parameter NUM_NEURONS, default 10: perceptrons in the bank driven in parallel.
REQ-003 SHALL have parameter SUM_WIDTH, default 11: signed width of each perceptron sum.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: request one inference.
REQ-007 SHALL have port hold, input, 1: stall the feed (memory not ready).
REQ-008 SHALL have port sums, input, NUM_NEURONS*SUM_WIDTH: flattened signed sums; neuron i occupies bits [i*SUM_WIDTH +: SUM_WIDTH].
REQ-009 SHALL have port addr, output, $clog2(NUM_INPUTS): shared read address for the input and weight memories.
REQ-010 SHALL have port rd_en, output, 1: memory read strobe; read data is valid one cycle later.
REQ-011 SHALL have port clear, output, 1: perceptron accumulator clear.
REQ-012 SHALL have port en, output, 1: perceptron accumulate enable.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port class_out, output, $clog2(NUM_NEURONS): index of the largest sum.
REQ-016 SHALL have port class_valid, output, 1: class_out holds a valid result.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, ARGMAX and DONE.
REQ-018 IDLE: start=1 -> CLEAR, and class_valid drops to 0; start is ignored in every other state.
REQ-019 CLEAR: assert clear=1 for exactly one cycle, set addr=0, then go to RUN.
REQ-020 RUN, hold=0: rd_en=1 and addr advances by 1 each cycle. RUN, hold=1: rd_en=0 and addr is frozen.
REQ-021 RUN: the cycle that issues addr=NUM_INPUTS-1 with rd_en=1 -> DRAIN; addr SHALL never pass NUM_INPUTS-1.
REQ-022 en SHALL equal rd_en delayed by one register stage in every state, giving exactly NUM_INPUTS en pulses per inference.
REQ-023 DRAIN: one cycle (carries the last en), then go to ARGMAX.
REQ-024 ARGMAX: scan neurons 0..NUM_NEURONS-1, one per cycle, with a signed compare.
REQ-025 ARGMAX: replace the running maximum only on strictly greater, so ties resolve to the lowest index.
REQ-026 ARGMAX: after NUM_NEURONS cycles, go to DONE.
REQ-027 DONE: done=1 for one cycle, class_out and class_valid=1 are updated, then go to IDLE.
REQ-028 class_out SHALL hold its value until the next DONE.
REQ-029 Latency with no hold: start sampled at cycle T -> done at T+NUM_INPUTS+NUM_NEURONS+3. Each hold cycle adds exactly 1.
REQ-030 start=1 in the DONE cycle SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE and force addr, rd_en, en, clear, done, busy, class_valid, class_out and the internal counters to 0.
REQ-032 Reset mid-inference SHALL abandon the inference with no done pulse; the first start after rst returns high SHALL run a complete inference.

Structure
REQ-033 The shared package nn_pkg SHALL hold the NUM_INPUTS, NUM_NEURONS and SUM_WIDTH defaults and the state enum type.
REQ-034 Argmax datapath (index counter, running max, best index) SHALL be the sub-module argmax_seq, driven by start/step strobes from the FSM.

Verification (NUM_INPUTS=4, NUM_NEURONS=3, SUM_WIDTH=11)
REQ-035 Start at cycle 0, hold=0, sums={5,-3,9} for neurons 0,1,2 -> clear at cycle 1, addr 0..3 at cycles 2..5, en at cycles 3..6, done at cycle 10, class_out=2.
REQ-036 Same stimulus with hold=1 at cycles 3-4 -> addr stays 1 during cycles 3-4, exactly 4 en pulses, done at cycle 12.
REQ-037 sums={7,7,-1} -> class_out=0; sums={-8,-2,-5} -> class_out=1 (signed compare).
REQ-038 start pulsed during RUN and during the DONE cycle -> no effect; a second start the next cycle after DONE -> second inference completes 10 cycles later.
REQ-039 rst=0 asynchronously during cycle 4 -> all outputs 0 immediately, no done pulse; start after release -> normal done 10 cycles later.
